// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a two-entry skid buffer, valid/ready handshake,
// synchronous flush and a saturating stall-cycle counter.
module pipe_skid_reg #(
    parameter int DATA_W = 200,
    parameter int EXC_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d, s_data_q, s_data_d;
    logic [EXC_W-1:0]    m_exc_q, m_exc_d, s_exc_q, s_exc_d;
    logic                m_bd_q, m_bd_d, s_bd_q, s_bd_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                in_fire, out_fire, valid_int;

    assign valid_int = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = valid_int & out_ready;

    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_exc_d  = m_exc_q;
        m_bd_d   = m_bd_q;
        s_data_d = s_data_q;
        s_exc_d  = s_exc_q;
        s_bd_d   = s_bd_q;
        if (flush) begin
            state_d  = EMPTY;
            m_data_d = '0;
            m_exc_d  = '0;
            m_bd_d   = 1'b0;
            s_data_d = '0;
            s_exc_d  = '0;
            s_bd_d   = 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d  = ONE;
                        m_data_d = in_data;
                        m_exc_d  = in_exc;
                        m_bd_d   = in_bd;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        m_data_d = in_data;
                        m_exc_d  = in_exc;
                        m_bd_d   = in_bd;
                    end else if (in_fire) begin
                        state_d  = FULL;
                        s_data_d = in_data;
                        s_exc_d  = in_exc;
                        s_bd_d   = in_bd;
                    end else if (out_fire) begin
                        state_d  = EMPTY;
                        m_data_d = '0;
                        m_exc_d  = '0;
                        m_bd_d   = 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d  = ONE;
                        m_data_d = s_data_q;
                        m_exc_d  = s_exc_q;
                        m_bd_d   = s_bd_q;
                        s_data_d = '0;
                        s_exc_d  = '0;
                        s_bd_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        in_ready_d = (state_d != FULL);
    end

    // Counts stalls in the flush cycle too; only reset clears it.
    always_comb begin
        stall_d = stall_q;
        if (valid_int && !out_ready && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            m_data_q   <= '0;
            m_exc_q    <= '0;
            m_bd_q     <= 1'b0;
            s_data_q   <= '0;
            s_exc_q    <= '0;
            s_bd_q     <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            m_data_q   <= m_data_d;
            m_exc_q    <= m_exc_d;
            m_bd_q     <= m_bd_d;
            s_data_q   <= s_data_d;
            s_exc_q    <= s_exc_d;
            s_bd_q     <= s_bd_d;
            stall_q    <= stall_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = valid_int;
    assign out_data  = m_data_q;
    assign out_exc   = m_exc_q;
    assign out_bd    = m_bd_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: reset, streaming, backpressure, exception
// fields, flush in FULL and stall-counter saturation with a 4-bit counter.
module tb_pipe_skid_reg;

    localparam int DATA_W = 16;
    localparam int EXC_W  = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [EXC_W-1:0]  in_exc;
    logic              in_bd;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [EXC_W-1:0]  out_exc;
    logic              out_bd;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_skid_reg #(.DATA_W(DATA_W), .EXC_W(EXC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_exc    (in_exc),
        .in_bd     (in_bd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_exc   (out_exc),
        .out_bd    (out_bd),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_exc"}, 32'(out_exc), 32'd0);
        chk({tag, "_bd"}, 32'(out_bd), 32'd0);
        chk({tag, "_occ"}, 32'(occupancy), 32'd0);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 16'hABCD;
        in_exc = '0; in_bd = 1'b0; out_ready = 1'b0;

        // reset with a beat offered
        step; step;
        chk_empty("rst");
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        reset = 1'b0; in_valid = 1'b0;
        step; step;
        chk_empty("post_rst");
        chk("post_rst_stall", 32'(stall_cnt), 32'd0);

        // streaming 1..8 at full rate
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 16'(i);
            step;
            chk($sformatf("stream_data%0d", i), 32'(out_data), 32'(i));
            chk($sformatf("stream_valid%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("stream_rdy%0d", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step;
        chk_empty("stream_end");
        chk("stream_stall", 32'(stall_cnt), 32'd0);

        // backpressure: two beats fill the skid
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0011;
        step;
        chk("bp_occ1", 32'(occupancy), 32'd1);
        chk("bp_data1", 32'(out_data), 32'h11);
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        in_data = 16'h0022;
        step;
        chk("bp_occ2", 32'(occupancy), 32'd2);
        chk("bp_rdy2", 32'(in_ready), 32'd0);
        chk("bp_data2", 32'(out_data), 32'h11);
        chk("bp_stall", 32'(stall_cnt), 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        step;
        chk("bp_drain_data", 32'(out_data), 32'h22);
        chk("bp_drain_occ", 32'(occupancy), 32'd1);
        step;
        chk_empty("bp_done");
        chk("bp_done_stall", 32'(stall_cnt), 32'd1);

        // exception fields travel through the skid entry
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0044; in_exc = 5'd3; in_bd = 1'b0;
        step;
        in_data = 16'h0055; in_exc = 5'd12; in_bd = 1'b1;
        step;
        chk("exc_m_exc", 32'(out_exc), 32'd3);
        chk("exc_m_bd", 32'(out_bd), 32'd0);
        chk("exc_occ", 32'(occupancy), 32'd2);
        in_valid = 1'b0; out_ready = 1'b1; in_exc = '0; in_bd = 1'b0;
        step;
        chk("exc_s_data", 32'(out_data), 32'h55);
        chk("exc_s_exc", 32'(out_exc), 32'd12);
        chk("exc_s_bd", 32'(out_bd), 32'd1);
        step;
        chk_empty("exc_done");
        chk("exc_stall", 32'(stall_cnt), 32'd2);

        // flush while FULL, with a beat offered in the flush cycle
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0066; in_exc = 5'd7; in_bd = 1'b1;
        step;
        in_data = 16'h0077;
        step;
        chk("fl_occ_pre", 32'(occupancy), 32'd2);
        chk("fl_stall_pre", 32'(stall_cnt), 32'd3);
        in_data = 16'h0033; in_exc = 5'd0; in_bd = 1'b0; flush = 1'b1;
        step;
        chk_empty("fl");
        chk("fl_stall", 32'(stall_cnt), 32'd4);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            chk($sformatf("fl_no33_%0d", i), 32'(out_valid), 32'd0);
        end
        chk("fl_stall_after", 32'(stall_cnt), 32'd4);

        // asynchronous reset from FULL
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0088;
        step;
        in_data = 16'h0099;
        step;
        chk("ar_occ_pre", 32'(occupancy), 32'd2);
        in_valid = 1'b0;
        reset = 1'b1;
        #2;
        chk_empty("ar");
        chk("ar_stall", 32'(stall_cnt), 32'd0);
        reset = 1'b0;

        // stall counter saturation at 15
        in_valid = 1'b1; in_data = 16'h00AA;
        step;
        chk("sat_start", 32'(stall_cnt), 32'd0);
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step;
            chk($sformatf("sat_cnt%0d", k), 32'(stall_cnt), (k < 15) ? 32'(k) : 32'd15);
        end
        chk("sat_data", 32'(out_data), 32'hAA);
        flush = 1'b1;
        step;
        flush = 1'b0;
        chk("sat_flush_cnt", 32'(stall_cnt), 32'd15);
        chk("sat_flush_occ", 32'(occupancy), 32'd0);
        step;
        chk("sat_hold_cnt", 32'(stall_cnt), 32'd15);
        reset = 1'b1;
        #2;
        chk("sat_reset_cnt", 32'(stall_cnt), 32'd0);
        reset = 1'b0;
        step;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised pipeline stage register for the five-stage MIPS core. It is the successor to the fixed-field EX/MEM latch.
- Carries an arbitrary packed payload plus exception code and branch-delay flag. A valid/ready handshake replaces the global stall wiring.
- A two-entry skid buffer keeps in_ready registered, so there is no combinational ready path between stages.
- A synchronous flush (exception/eret request) inserts bubbles. A saturating stall counter supports performance analysis.

Parameters:
- DATA_W, 200, payload width in bits (ALU out, store data, PC, instr, ctrl, packed by the instantiating stage).
- EXC_W, 5, exception code width.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous kill of all held entries (CP0 exception request).
- in_valid  in  1  upstream holds a valid beat.
- in_ready  out  1  stage can accept a beat; driven from a register.
- in_data  in  DATA_W  upstream payload.
- in_exc  in  EXC_W  upstream exception code.
- in_bd  in  1  upstream branch-delay flag.
- out_valid  out  1  main entry holds a valid beat.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  main entry payload.
- out_exc  out  EXC_W  main entry exception code.
- out_bd  out  1  main entry branch-delay flag.
- occupancy  out  2  entries held (0, 1, 2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Storage:
  - Main entry M = {data, exc, bd}; skid entry S, same fields.
  - State is EMPTY (0 entries), ONE (M valid) or FULL (M and S valid).
- Outputs:
  - out_valid = (state != EMPTY).
  - out_data/out_exc/out_bd = M.
  - in_ready = (state != FULL).
  - occupancy = 0, 1 or 2 per state.
  - No output depends combinationally on out_ready, in_valid or in_data.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_data may change freely while in_valid=0.
- Transitions (when flush=0):
  - EMPTY, in_fire -> ONE, M <= in.
  - ONE, in_fire & out_fire -> ONE, M <= in.
  - ONE, in_fire only -> FULL, S <= in.
  - ONE, out_fire only -> EMPTY, M <= 0.
  - ONE, neither -> ONE, M holds.
  - FULL, out_fire -> ONE, M <= S, S <= 0. in_fire is impossible here (in_ready=0).
  - FULL, no out_fire -> hold.
- Ordering is strict FIFO. A beat accepted into S never overtakes M.
- Latency: a beat accepted in cycle t appears on out_* in cycle t+1 when the stage was EMPTY, or ONE with out_fire.
- Throughput: 1 beat/cycle with out_ready held at 1.
- Bubble convention: any vacated entry is cleared to all-zero. out_data, out_exc and out_bd read 0 whenever out_valid=0.
- Flush:
  - Highest priority over all handshake activity. The next state is EMPTY and M, S <= 0.
  - A beat offered in the flush cycle is discarded, even though in_ready was 1.
  - out_fire in the flush cycle is still a valid downstream transfer; downstream owns that decision.
- stall_cnt:
  - Increments by 1 each cycle out_valid & !out_ready, including the flush cycle.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; unaffected by flush.
- Reset (asynchronous, any state, including mid-FULL):
  - state=EMPTY, M=S=0, stall_cnt=0.
  - Resulting outputs: out_valid=0, out_data=0, out_exc=0, out_bd=0, occupancy=0, in_ready=1.
  - Beats held at reset are lost.
- Simultaneous flush and reset: reset wins (same end state).

Test Plan:
- Reset: assert reset with in_valid=1, in_data=0xABCD -> out_valid=0, out_data=0, occupancy=0, in_ready=1, stall_cnt=0. After release with in_valid=0, all of these hold.
- Streaming: out_ready=1; in_valid=1 for 8 cycles, data 1..8 -> out_data 1..8 on consecutive cycles starting one cycle after the first accept, out_valid=1 throughout, in_ready never 0.
- Backpressure: out_ready=0; send A=0x11, then B=0x22 -> occupancy 1, then 2; in_ready=0; out_data=0x11 held. Raise out_ready -> 0x11, then 0x22, then out_valid=0, out_data=0.
- Flush in FULL: occupancy=2, in_valid=1, in_data=0x33, pulse flush -> next cycle occupancy=0, out_valid=0, out_data/exc/bd=0, in_ready=1; 0x33 never emerges. stall_cnt is unchanged apart from the flush-cycle increment.
- Stall saturation: CNT_W=4; one beat held with out_ready=0 for 20 cycles -> stall_cnt reads 15 from cycle 15 onward. Flush leaves it at 15; reset zeroes it.
- Exception fields: in_exc=5'd12, in_bd=1 accepted into S behind a stalled beat in M -> after M drains, out_exc=12 and out_bd=1 with the matching data.
